cdc_hs_tx_ctrl: RTL
===================

CDC_HS_TX_CTRL -- requirements
Module: cdc_hs_tx_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 SHALL provide parameter STAGES, default 2, flop depth of the ack synchronizer (>=1).
REQ-003 SHALL provide parameter TIMEOUT, default 255, watchdog limit in clk cycles (1..65535).
REQ-004 SHALL provide port: clk  input  1  sole clock; all state updates on posedge.
REQ-005 SHALL provide port: reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-006 SHALL provide port: in_valid  input  1  local producer offers in_data.
REQ-007 SHALL provide port: in_data  input  WIDTH  payload to transfer.
REQ-008 SHALL provide port: in_ready  output  1  controller accepts payload this cycle.
REQ-009 SHALL provide port: tx_req  output  1  four-phase request to the remote domain, driven from a flop.
REQ-010 SHALL provide port: tx_data  output  WIDTH  registered payload toward the remote domain.
REQ-011 SHALL provide port: tx_ack  input  1  asynchronous acknowledge from the remote domain.
REQ-012 SHALL provide port: busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL provide port: xfer_cnt  output  16  completed-transfer count.
REQ-014 SHALL provide port: err_clr  input  1  clears error.
REQ-015 SHALL provide port: error  output  1  sticky watchdog flag.

Function
REQ-016 SHALL pass tx_ack through STAGES flops clocked by clk; FSM uses only the synchronized value ack_s.
REQ-017 SHALL implement FSM states IDLE, REQ_HI and WAIT_LO.
REQ-018 SHALL drive in_ready=1 only in IDLE; a handshake occurs on in_valid&&in_ready.
REQ-019 SHALL, on a handshake, capture in_data into tx_data, set tx_req=1 and enter REQ_HI on the next cycle (latency 1).
REQ-020 SHALL, in REQ_HI with ack_s=1, set tx_req=0 and enter WAIT_LO on the next cycle.
REQ-021 SHALL, in WAIT_LO with ack_s=0, enter IDLE and increment xfer_cnt (wraps 0xFFFF->0x0000).
REQ-022 SHALL hold tx_data stable from capture until the FSM re-enters IDLE.
REQ-023 SHALL ignore ack_s in IDLE; a spurious ack_s=1 in IDLE SHALL block nothing and change no state.
REQ-024 SHALL allow a new handshake in the same cycle the FSM is in IDLE after WAIT_LO (minimum 1 idle cycle between transfers).

Reset
REQ-025 SHALL, while reset=0 at posedge clk, force state IDLE, tx_req=0, tx_data=0, xfer_cnt=0, error=0, watchdog=0 and all synchronizer flops to 0, including mid-transfer.
REQ-026 SHALL, with reset=0, drive in_ready=1, busy=0 and xfer_cnt=0 after the reset edge.

Configuration
REQ-027 SHALL compile the watchdog only when macro CDC_HS_TIMEOUT_EN is defined.
REQ-028 SHALL, with CDC_HS_TIMEOUT_EN defined, count cycles spent in REQ_HI or WAIT_LO and clear the count on every state change.
REQ-029 SHALL, with CDC_HS_TIMEOUT_EN defined, set error=1 when the count reaches TIMEOUT; in REQ_HI, tx_req SHALL drop and the FSM SHALL enter WAIT_LO; in WAIT_LO, the FSM SHALL stay; xfer_cnt SHALL NOT increment for an aborted transfer.
REQ-030 SHALL, with CDC_HS_TIMEOUT_EN defined, clear error on err_clr=1; if err_clr and a new timeout coincide, the timeout SHALL win.
REQ-031 SHALL, without CDC_HS_TIMEOUT_EN, tie error to 0, ignore err_clr, keep the port list unchanged and wait indefinitely.

Structure
REQ-032 SHALL place the FSM state enum and XFER_CNT_W=16 in shared package cdc_hs_pkg.
REQ-033 SHALL implement the ack synchronizer as sub-module cdc_sync_n (parameter STAGES, synchronous active-low reset).

Verification
REQ-034 SHALL cover a single transfer: in_data=0xA5 with tx_ack echoing tx_req after 3 cycles -> tx_req rises 1 cycle after handshake, tx_data=0xA5 held, xfer_cnt=1, busy=0 afterwards.
REQ-035 SHALL cover back-to-back transfers: in_valid held high with data 0x01..0x04 -> exactly 4 transfers in order, in_ready low throughout each transfer, xfer_cnt=4.
REQ-036 SHALL cover reset mid-transfer: reset=0 during REQ_HI -> next cycle tx_req=0, state IDLE, xfer_cnt=0, tx_data=0.
REQ-037 SHALL cover timeout with CDC_HS_TIMEOUT_EN defined: TIMEOUT=10 and tx_ack stuck at 0 -> error=1 exactly 10 cycles after REQ_HI entry, tx_req=0, xfer_cnt unchanged; a later err_clr=1 gives error=0.
REQ-038 SHALL cover wrap-around: preload xfer_cnt to 0xFFFF via 65535 transfers with a fast ack model -> next transfer gives xfer_cnt=0x0000.
REQ-039 SHALL cover a spurious ack: tx_ack=1 while IDLE -> no state change, and a subsequent handshake stalls in REQ_HI until the ack completes a full high-low cycle.

Source files
------------

// File: rtl/cdc_hs_pkg.sv
// Shared types for the four-phase CDC handshake transmitter.
// Holds the controller state encoding and the transfer counter width.
package cdc_hs_pkg;

  localparam int unsigned XFER_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_HI  = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

endpackage

// File: rtl/cdc_sync_n.sv
// N-flop level synchronizer with synchronous active-low reset.
// The output is taken from the last flop in the chain.
module cdc_sync_n #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// Four-phase request/acknowledge transmitter toward a remote clock domain.
// Optional handshake watchdog is compiled in with macro CDC_HS_TIMEOUT_EN.
module cdc_hs_tx_ctrl
  import cdc_hs_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STAGES  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  tx_req,
  output logic [WIDTH-1:0]      tx_data,
  input  logic                  tx_ack,
  output logic                  busy,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  input  logic                  err_clr,
  output logic                  error
);

  state_t                  state, state_n;
  logic                    ack_s;
  logic                    hs;
  logic                    timeout;
  logic                    aborted;
  logic                    done;
  logic [XFER_CNT_W-1:0]   cnt_q;

  cdc_sync_n #(.STAGES(STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tx_ack),
    .q     (ack_s)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign hs       = in_valid && in_ready;
  assign xfer_cnt = cnt_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (hs) state_n = REQ_HI;
      REQ_HI:  if (ack_s || timeout) state_n = WAIT_LO;
      WAIT_LO: if (!ack_s && !timeout) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A transfer that was cut short by the watchdog still drains through WAIT_LO but is not counted.
  assign done = (state == WAIT_LO) && (state_n == IDLE) && !aborted;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      tx_req  <= 1'b0;
      tx_data <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_n;
      if (hs) begin
        tx_req  <= 1'b1;
        tx_data <= in_data;
      end else if ((state == REQ_HI) && (state_n == WAIT_LO)) begin
        tx_req <= 1'b0;
      end
      if (done) cnt_q <= cnt_q + XFER_CNT_W'(1);
    end
  end

`ifdef CDC_HS_TIMEOUT_EN
  logic [15:0] wd_q;
  logic        aborted_q;
  logic        err_q;

  assign timeout = (state != IDLE) && (wd_q == 16'(TIMEOUT - 1));
  assign aborted = aborted_q;
  assign error   = err_q;

  // The watchdog restarts on each state change, and after firing in WAIT_LO it re-arms.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q      <= '0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if ((state_n != state) || timeout) wd_q <= '0;
      else if (state != IDLE)            wd_q <= wd_q + 16'd1;

      if (hs)           aborted_q <= 1'b0;
      else if (timeout) aborted_q <= 1'b1;

      if (timeout)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign aborted    = 1'b0;
  assign error      = 1'b0;
  assign unused_cfg = err_clr | (TIMEOUT == 0);
`endif

endmodule
